// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter with a small byte FIFO in front of it.
// Each clk edge that samples tx_ready=1 writes tx_data into the FIFO. The FSM
// pops one byte at a time and sends it LSB-first as start/8 data/stop bits,
// BAUD_DIV clocks per bit. Frames are sent back to back while bytes remain.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   tx_ready   write strobe, one byte per sampling edge
//   tx_data    byte to enqueue
//   tx         registered serial line, idle high
//   busy       FIFO non-empty or a frame in progress
//   fifo_full  FIFO holds FIFO_DEPTH bytes
//   overflow   sticky, set when a write is dropped because the FIFO is full
//   byte_sent  one-cycle pulse on the edge that completes a stop bit
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 5208,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       byte_sent
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [1:0]        state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic wr_en, rd_en, baud_end, have_byte;

    // Writes are judged against the pre-edge count, so a pop on the same edge
    // never frees room for a write arriving while full.
    assign wr_en     = tx_ready && (count < DEPTH_C);
    assign have_byte = (count != '0);
    assign baud_end  = (baud_cnt == BAUD_LAST);
    // Pop either from IDLE or at the end of a stop bit (back-to-back frames).
    assign rd_en     = have_byte && ((state == IDLE) || (state == STOP && baud_end));

    assign fifo_full = (count == DEPTH_C);
    assign busy      = (state != IDLE) || have_byte;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (tx_ready && !wr_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_sent <= 1'b0;
        end else begin
            byte_sent <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (rd_en) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next bit is shift[1] because the shift lands this same edge.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin // STOP
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        byte_sent <= 1'b1;
                        if (rd_en) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (BAUD_DIV=4, FIFO_DEPTH=4). The reference model
// schedules every accepted byte on a timeline: a byte written at edge W starts
// its frame at max(W+1, previous start + 10*BAUD_DIV) and sits in the FIFO
// from W until that start edge. Occupancy, busy, fifo_full, overflow and
// expected frames all follow from that schedule. A monitor decodes the tx line
// and compares frames and byte_sent pulses against scoreboard queues.
module tb_uart_tx_fifo;
    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BD;
    localparam int NEVER = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, busy, fifo_full, overflow, byte_sent;

    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow),
        .byte_sent(byte_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         wr;
        int         st;
        logic [7:0] d;
    } acc_t;

    acc_t acc_q[$];   // every accepted byte with its schedule
    acc_t exp_q[$];   // frames the monitor has yet to see
    int   sent_q[$];  // expected byte_sent edges
    int   ovf_edge = NEVER;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp_v, cyc);
        end
    endtask

    // bytes waiting in the FIFO just before edge e
    function automatic int occ_pre(input int e);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i].wr < e && acc_q[i].st >= e) n++;
        return n;
    endfunction

    // bytes waiting in the FIFO just after edge c
    function automatic int occ_post(input int c);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i].wr <= c && acc_q[i].st > c) n++;
        return n;
    endfunction

    function automatic bit model_busy(input int c);
        foreach (acc_q[i]) if (acc_q[i].wr <= c && acc_q[i].st + FRAME > c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input int e, input logic [7:0] d);
        acc_t a;
        int   st;
        if (occ_pre(e) < DEPTH) begin
            st = e + 1;
            if (acc_q.size() != 0 && acc_q[$].st + FRAME > st) st = acc_q[$].st + FRAME;
            a.wr = e; a.st = st; a.d = d;
            acc_q.push_back(a);
            exp_q.push_back(a);
            sent_q.push_back(st + FRAME);
        end else if (ovf_edge == NEVER) begin
            ovf_edge = e;
        end
    endtask

    // Drive one cycle of stimulus; takes effect on the next rising edge.
    task automatic step(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        tx_ready = v;
        tx_data  = d;
        if (v) model_write(cyc + 1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tx_ready = 1'b0;
        #1;
        chk("rst_tx_async", tx, 1);
        chk("rst_busy_async", busy, 0);
        chk("rst_byte_sent", byte_sent, 0);
        acc_q.delete();
        exp_q.delete();
        sent_q.delete();
        ovf_edge = NEVER;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_overflow", overflow, 0);
        chk("rst_fifo_full", fifo_full, 0);
        rst = 1'b1;
    endtask

    // Monitor: per-cycle status checks plus frame decode from the tx line.
    initial begin
        bit         hunting = 1'b1;
        bit         prev_tx = 1'b1;
        int         f_st = 0;
        logic [7:0] f_dat = '0;
        int         rel, bi;
        acc_t       e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hunting = 1'b1;
                prev_tx = 1'b1;
            end else begin
                chk("busy", busy, int'(model_busy(cyc)));
                chk("fifo_full", fifo_full, int'(occ_post(cyc) == DEPTH));
                chk("overflow", overflow, int'(cyc >= ovf_edge));
                if (!model_busy(cyc)) chk("tx_idle", tx, 1);
                if (byte_sent) begin
                    if (sent_q.size() == 0) chk("byte_sent_unexpected", 1, 0);
                    else chk("byte_sent_cycle", cyc, sent_q.pop_front());
                end
                if (hunting) begin
                    if (prev_tx && !tx) begin
                        hunting = 1'b0;
                        f_st    = cyc;
                        f_dat   = '0;
                    end
                end else begin
                    rel = cyc - f_st;
                    if (rel >= BD + BD / 2 && (rel - BD / 2) % BD == 0) begin
                        bi = (rel - BD / 2) / BD - 1;
                        if (bi < 8) begin
                            f_dat[bi] = tx;
                        end else begin
                            chk("stop_bit", tx, 1);
                            if (exp_q.size() == 0) begin
                                chk("frame_unexpected", f_dat, -1);
                            end else begin
                                e = exp_q.pop_front();
                                chk("frame_start", f_st, e.st);
                                chk("frame_data", f_dat, e.d);
                            end
                            hunting = 1'b1;
                        end
                    end
                end
                prev_tx = tx;
            end
        end
    end

    initial begin
        logic [7:0] t2 [4];
        t2[0] = 8'h0E; t2[1] = 8'h00; t2[2] = 8'h02; t2[3] = 8'h00;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_fifo_full", fifo_full, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_byte_sent", byte_sent, 0);
        rst = 1'b1;

        // idle line
        idle(1000);

        // single 0x55 frame
        step(1'b1, 8'h55);
        idle(60);

        // four strobes 3 cycles apart -> contiguous frames
        for (int i = 0; i < 4; i++) begin
            step(1'b1, t2[i]);
            idle(2);
        end
        idle(200);
        chk("t2_overflow", overflow, 0);

        // six-cycle strobe into a 4-deep FIFO: sixth byte dropped
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        step(1'b0, 8'h00);
        chk("t3_overflow", overflow, 1);
        idle(260);
        chk("t3_overflow_sticky", overflow, 1);

        // pointer wrap: 3 bytes, drain, 4 more
        for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i));
        idle(160);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i));
        idle(220);

        // reset during data bit 3 of 0xA5 with two bytes queued
        step(1'b1, 8'hA5);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b0, 8'h00);
        idle(14);
        do_reset();
        idle(100);
        chk("t5_overflow", overflow, 0);
        chk("t5_tx", tx, 1);

        // randomized traffic with occasional bursts
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int j = 0; j < 6; j++) step(1'b1, 8'($urandom));
            end else begin
                step(($urandom_range(0, 19) == 0), 8'($urandom));
            end
        end
        idle(320);

        chk("frames_outstanding", exp_q.size(), 0);
        chk("byte_sent_outstanding", sent_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Serial UART transmitter that consumes the byte-strobe interface driven by the divider controller (tx_ready pulse plus tx_data).
- Buffers bytes in a small FIFO and serialises each as an 8N1 frame (1 start, 8 data LSB-first, 1 stop) on the board TX pin.
- Sits between the controller and the physical UART line, so controller strobes spaced closer than one frame time are not lost.

Parameters:
BAUD_DIV, 5208, clocks per bit (50 MHz / 9600 baud); must be ≥ 2
FIFO_DEPTH, 4, byte FIFO depth; power of two
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
tx_ready  input  1  write strobe; each clk edge sampling 1 enqueues tx_data
tx_data  input  8  byte to transmit
tx  output  1  serial line; idle high
busy  output  1  1 while FIFO non-empty or a frame is in progress
fifo_full  output  1  FIFO count == FIFO_DEPTH
overflow  output  1  sticky; set when a write is dropped; cleared only by reset
byte_sent  output  1  one-cycle pulse on the edge that completes a stop bit

Behaviour:
- Reset (rst=0, async): tx=1, busy=0, fifo_full=0, overflow=0, byte_sent=0. FIFO pointers and count=0, state=IDLE, baud counter=0, bit index=0.
- Reset mid-frame abandons the frame immediately; no partial stop bit is sent.

FIFO:
- Write when tx_ready=1 and count<FIFO_DEPTH, with count taken before the edge. No write-through when full.
- Read (pop) only from the FSM as defined below.
- Simultaneous write and pop: both occur and count is unchanged. This is legal at any count ≥ 1; at count==FIFO_DEPTH the write is still dropped.
- Write when full: byte discarded, overflow<=1, count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- tx_ready held high for N cycles enqueues N copies. The controller's strobe is one cycle wide.

FSM, states IDLE, START, DATA, STOP:
- IDLE: tx=1. If count>0: load head byte into shift register, pop, baud_cnt<=0, tx<=0, go to START.
- START: tx=0 for BAUD_DIV clocks. When baud_cnt==BAUD_DIV-1: baud_cnt<=0, bit_idx<=0, tx<=shift[0], go to DATA.
- DATA: tx=current bit, held BAUD_DIV clocks each. At end of bit: shift right, bit_idx+1. After bit_idx==7 completes: tx<=1, go to STOP.
- STOP: tx=1 for BAUD_DIV clocks. At end: byte_sent<=1 for one cycle.
  - If count>0, load and pop the next byte, tx<=0, go to START on the same edge. Frames are back-to-back with no idle gap.
  - Otherwise go to IDLE.
- Otherwise baud_cnt increments each clock. baud_cnt counts 0..BAUD_DIV-1 and never exceeds BAUD_DIV-1.

Timing:
- Latency: byte written at edge E0 → tx falls at edge E1.
- Frame length: exactly 10×BAUD_DIV clocks, start-bit falling edge to end of stop bit.
- byte_sent rises on edge E1+10×BAUD_DIV for the first byte.

Outputs:
- tx is registered.
- busy = (state!=IDLE) || (count!=0), registered or combinational from registers.
- fifo_full is combinational from count.

Test Plan:
1. BAUD_DIV=4. Single write 0x55 at E0 → tx starting E1, 4 clocks per level: 0,1,0,1,0,1,0,1,0,1. byte_sent pulses at E41; busy falls at E41; tx stays 1 afterwards.
2. BAUD_DIV=4. Controller result for 100/7, bytes 0x0E,0x00,0x02,0x00 strobed 3 cycles apart → four contiguous 40-clock frames, LSB-first data 0x0E,0x00,0x02,0x00. No idle gap between frames, 4 byte_sent pulses 40 clocks apart, overflow=0.
3. BAUD_DIV=4, DEPTH=4. tx_ready high 6 consecutive cycles with data 0x01..0x06 → bytes 0x01..0x05 transmitted in order. 0x06 dropped; overflow=1 from the edge after E5 and stays 1; fifo_full=1 after E4.
4. Wrap-around: write 3 bytes, let them drain, then write 4 more → all 7 received in order. Pointer wrap causes no corruption; fifo_full asserts only with 4 queued.
5. Reset mid-frame: rst=0 during DATA bit 3 of 0xA5 with 2 bytes queued → tx=1 and busy=0 immediately (async). After release, tx stays 1 with no residual frame and overflow=0.
6. Idle line: no writes for 1000 cycles after reset → tx=1, busy=0, byte_sent never pulses.
